// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-address generator: enable levels, stall-bus width
// and the PC state encoding.
package pc_gen_pkg;

  localparam logic ENABLE     = 1'b1;
  localparam logic DISABLE    = 1'b0;
  localparam int   SIGNAL_BUS = 6;

  typedef enum logic [1:0] {
    PC_S_RESET = 2'd0,
    PC_S_ARM   = 2'd1,
    PC_S_RUN   = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds one branch redirect that arrived while the PC stage was stalled, until the
// stall releases and the PC consumes it.
module pc_redirect_latch
  import pc_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  capture,
  input  logic [ADDR_WIDTH-1:0] capture_target,
  input  logic                  consume,
  output logic                  pending_valid,
  output logic [ADDR_WIDTH-1:0] pending_target
);

  // NOTE: clocked state always uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (clear)        pending_valid <= DISABLE;
    else if (capture) pending_valid <= ENABLE;
    else if (consume) pending_valid <= DISABLE;
  end

  // NOTE: the target is plain data qualified by pending_valid, so it carries no reset.
  always_ff @(posedge clock) begin
    if (capture && !clear) pending_target <= capture_target;
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter register with reset/arm sequencing, next-PC priority mux and a
// captured-branch slot for redirects that arrive during a stall.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INST_BYTES   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STALL_WIDTH  = SIGNAL_BUS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STALL_WIDTH-1:0] stall,
  input  logic                   branch_signal,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  flush_target,
  output logic [ADDR_WIDTH-1:0]  program_counter,
  output logic                   chip_enable,
  output logic                   redirect_pending,
  output logic                   pc_misaligned
);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);

  pc_state_e             state;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  want_capture;
  logic                  want_consume;
  logic                  running;
  logic                  pending_valid;
  logic [ADDR_WIDTH-1:0] pending_target;
  logic                  unused_stall_bits;

  // Only the PC-stage bit matters; the rest of the bus is shared with later stages.
  assign unused_stall_bits = ^stall;

  // The cycle that enters S_ARM is not "running"; from S_ARM onwards the mux drives PC.
  assign running = (state != PC_S_RESET);

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    next_pc      = program_counter + STEP;
    want_capture = 1'b0;
    want_consume = 1'b0;
    if (flush) begin
      next_pc = flush_target;
    end else if (stall[0]) begin
      next_pc      = program_counter;
      want_capture = branch_signal;
    end else if (pending_valid) begin
      next_pc      = pending_target;
      want_consume = 1'b1;
    end else if (branch_signal) begin
      next_pc = branch_target;
    end
  end

  pc_redirect_latch #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_redirect_latch (
    .clock          (clock),
    .clear          (reset || (running && flush)),
    .capture        (running && want_capture),
    .capture_target (branch_target),
    .consume        (running && want_consume),
    .pending_valid  (pending_valid),
    .pending_target (pending_target)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= PC_S_RESET;
      program_counter <= RESET_VECTOR;
      chip_enable     <= DISABLE;
    end else begin
      unique case (state)
        PC_S_RESET: begin
          state           <= PC_S_ARM;
          program_counter <= RESET_VECTOR;
          chip_enable     <= ENABLE;
        end
        default: begin
          state           <= PC_S_RUN;
          program_counter <= next_pc;
          chip_enable     <= ENABLE;
        end
      endcase
    end
  end

  assign redirect_pending = pending_valid;
  assign pc_misaligned    = |(program_counter & ALIGN_MASK);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: two parameterisations driven by the same stimulus,
// each compared every cycle against a cycle-level behavioural model.
module tb_pc_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        branch_signal;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_target;

  logic [31:0] pc_a, pc_b;
  logic        ce_a, ce_b, pend_a, pend_b, mis_a, mis_b;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  pc_gen dut_a (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_signal(branch_signal), .branch_target(branch_target),
    .flush(flush), .flush_target(flush_target),
    .program_counter(pc_a), .chip_enable(ce_a),
    .redirect_pending(pend_a), .pc_misaligned(mis_a)
  );

  pc_gen #(.INST_BYTES(2), .RESET_VECTOR(32'h1000)) dut_b (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_signal(branch_signal), .branch_target(branch_target),
    .flush(flush), .flush_target(flush_target),
    .program_counter(pc_b), .chip_enable(ce_b),
    .redirect_pending(pend_b), .pc_misaligned(mis_b)
  );

  // Behavioural model: what the fetch unit must present after each edge.
  typedef struct {
    logic [31:0] pc;
    bit          ce;
    bit          pend;
    logic [31:0] tgt;
    bit          live;
  } model_t;

  model_t ma, mb;
  bit     model_ok = 1'b0;

  function automatic model_t step(model_t m, int unsigned ib, logic [31:0] rv,
                                  bit rst, bit stl, bit br, logic [31:0] bt,
                                  bit fl, logic [31:0] ft);
    model_t n = m;
    if (rst) begin
      n.pc = rv; n.ce = 1'b0; n.pend = 1'b0; n.live = 1'b0;
    end else if (!m.live) begin
      n.live = 1'b1; n.ce = 1'b1; n.pc = rv;
    end else if (fl) begin
      n.pc = ft; n.pend = 1'b0;
    end else if (stl) begin
      if (br) begin n.pend = 1'b1; n.tgt = bt; end
    end else if (m.pend) begin
      n.pc = m.tgt; n.pend = 1'b0;
    end else if (br) begin
      n.pc = bt;
    end else begin
      n.pc = m.pc + ib;
    end
    return n;
  endfunction

  always @(posedge clock) begin
    ma <= step(ma, 4, 32'h0, reset, stall[0], branch_signal, branch_target, flush, flush_target);
    mb <= step(mb, 2, 32'h1000, reset, stall[0], branch_signal, branch_target, flush, flush_target);
    if (reset) model_ok <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_ok) begin
      check("a_pc",   pc_a,   ma.pc);
      check("a_ce",   32'(ce_a),   32'(ma.ce));
      check("a_pend", 32'(pend_a), 32'(ma.pend));
      check("a_mis",  32'(mis_a),  32'((ma.pc % 4) != 0));
      check("b_pc",   pc_b,   mb.pc);
      check("b_ce",   32'(ce_b),   32'(mb.ce));
      check("b_pend", 32'(pend_b), 32'(mb.pend));
      check("b_mis",  32'(mis_b),  32'((mb.pc % 2) != 0));
    end
  end

  task automatic idle();
    stall = '0; branch_signal = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle(); branch_target = '0; flush_target = '0;
    repeat (3) @(negedge clock);
    check("rst_ce", 32'(ce_a), 32'h0);
    check("rst_pc", pc_a, 32'h0);
    check("rst_b_pc", pc_b, 32'h1000);
    reset = 1'b0;
    @(negedge clock);
    check("arm_ce", 32'(ce_a), 32'h1);
    check("arm_pc", pc_a, 32'h0);
    check("arm_b_pc", pc_b, 32'h1000);
    @(negedge clock);
    check("seq1_pc", pc_a, 32'h4);
    check("seq1_b_pc", pc_b, 32'h1002);
    @(negedge clock);
    check("seq2_pc", pc_a, 32'h8);
    check("seq2_b_pc", pc_b, 32'h1004);
    repeat (2) @(negedge clock);
    check("pre_stall_pc", pc_a, 32'h10);

    // Branch captured under a two-cycle stall.
    stall = 6'h01; branch_signal = 1'b1; branch_target = 32'h100;
    @(negedge clock);
    check("stall1_pc", pc_a, 32'h10);
    check("stall1_pend", 32'(pend_a), 32'h1);
    branch_signal = 1'b0;
    @(negedge clock);
    check("stall2_pc", pc_a, 32'h10);
    stall = '0;
    @(negedge clock);
    check("release_pc", pc_a, 32'h100);
    check("release_pend", 32'(pend_a), 32'h0);
    @(negedge clock);
    check("after_branch_pc", pc_a, 32'h104);

    // Flush wins over a pending redirect, a new branch and the stall.
    branch_signal = 1'b1; branch_target = 32'h40;
    @(negedge clock);
    check("br40_pc", pc_a, 32'h40);
    stall = 6'h01; branch_target = 32'h300;
    @(negedge clock);
    check("pend300", 32'(pend_a), 32'h1);
    flush = 1'b1; flush_target = 32'h180; branch_target = 32'h200;
    @(negedge clock);
    check("flush_pc", pc_a, 32'h180);
    check("flush_pend", 32'(pend_a), 32'h0);
    idle();
    @(negedge clock);
    check("post_flush_pc", pc_a, 32'h184);

    // Wrap at the top of the address space.
    flush = 1'b1; flush_target = 32'hFFFF_FFFC;
    @(negedge clock);
    idle();
    @(negedge clock);
    check("wrap_pc", pc_a, 32'h0);

    // Misaligned target loads as given.
    branch_signal = 1'b1; branch_target = 32'h102;
    @(negedge clock);
    check("mis_pc", pc_a, 32'h102);
    check("mis_flag", 32'(mis_a), 32'h1);
    idle();
    @(negedge clock);
    check("mis_next_pc", pc_a, 32'h106);
    check("mis_next_flag", 32'(mis_a), 32'h1);

    // Reset mid-operation discards the pending redirect.
    stall = 6'h01; branch_signal = 1'b1; branch_target = 32'h500;
    @(negedge clock);
    check("pre_rst_pend", 32'(pend_a), 32'h1);
    reset = 1'b1; branch_signal = 1'b0;
    @(negedge clock);
    check("mid_rst_pc", pc_a, 32'h0);
    check("mid_rst_ce", 32'(ce_a), 32'h0);
    check("mid_rst_pend", 32'(pend_a), 32'h0);
    reset = 1'b0; idle();
    repeat (2) @(negedge clock);

    // Randomised traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      stall         = ($urandom_range(0, 2) == 0) ? (6'($urandom) | 6'h01) : (6'($urandom) & 6'h3E);
      branch_signal = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      flush_target  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      @(negedge clock);
    end
    idle(); reset = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
